// File: rtl/bus_join.sv
// bus_join: joins an 8-bit G field and a 4-bit T field into 12-bit {T, G} words behind a small output FIFO.
// Optional BUS_JOIN_PARITY_EN adds an even-parity bit per stored word, presented on k_parity.
module bus_join #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       g_data,
  input  logic             g_valid,
  output logic             g_ready,
  input  logic [3:0]       t_data,
  input  logic             t_valid,
  output logic             t_ready,
  output logic [11:0]      k_data,
  output logic             k_valid,
  input  logic             k_ready,
  output logic [CNT_W-1:0] word_count
`ifdef BUS_JOIN_PARITY_EN
  ,
  output logic             k_parity
`endif
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
`ifdef BUS_JOIN_PARITY_EN
  localparam int EW = 13;
`else
  localparam int EW = 12;
`endif
  logic             g_full_q, g_full_d, t_full_q, t_full_d;
  logic [7:0]       g_reg_q, g_reg_d;
  logic [3:0]       t_reg_q, t_reg_d;
  logic [AW:0]      count_q, count_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] word_count_q, word_count_d;
  logic [EW-1:0]    mem_q [DEPTH];
  logic [EW-1:0]    head, entry;
  logic             pop, fire, g_load, t_load;
  always_comb begin
    head         = mem_q[rd_ptr_q];
    k_valid      = count_q != '0;
    pop          = k_valid && k_ready;
    fire         = g_full_q && t_full_q && (count_q < (AW+1)'(DEPTH) || pop);
    g_ready      = !g_full_q || fire;
    t_ready      = !t_full_q || fire;
    g_load       = g_valid && g_ready;
    t_load       = t_valid && t_ready;
    g_full_d     = g_load || (g_full_q && !fire);
    t_full_d     = t_load || (t_full_q && !fire);
    g_reg_d      = g_load ? g_data : g_reg_q;
    t_reg_d      = t_load ? t_data : t_reg_q;
    count_d      = count_q + (AW+1)'(fire) - (AW+1)'(pop);
    rd_ptr_d     = rd_ptr_q + AW'(pop);
    wr_ptr_d     = wr_ptr_q + AW'(fire);
    word_count_d = word_count_q + CNT_W'(fire);
    k_data       = k_valid ? head[11:0] : '0;
    word_count   = word_count_q;
`ifdef BUS_JOIN_PARITY_EN
    entry        = {^{t_reg_q, g_reg_q}, t_reg_q, g_reg_q};
    k_parity     = k_valid && head[12];
`else
    entry        = {t_reg_q, g_reg_q};
`endif
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      g_full_q     <= 1'b0;
      t_full_q     <= 1'b0;
      g_reg_q      <= '0;
      t_reg_q      <= '0;
      count_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      word_count_q <= '0;
    end else begin
      g_full_q     <= g_full_d;
      t_full_q     <= t_full_d;
      g_reg_q      <= g_reg_d;
      t_reg_q      <= t_reg_d;
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      word_count_q <= word_count_d;
    end
  end
  // Storage is not cleared on reset; k_valid gates what the consumer sees.
  always_ff @(posedge clk) begin
    if (fire && !reset) mem_q[wr_ptr_q] <= entry;
  end
endmodule
